// File: rtl/attack_roll_engine_pkg.sv
// Shared definitions for the attack roll engine: attack type codes, result codes,
// FSM state encoding and a small width helper.
// Imported by the interface consumers, the top and the testbench.
package attack_roll_engine_pkg;

    // Attack type codes carried on req_type
    localparam int ATK_STANDBY = 0;
    localparam int ATK_LIGHT   = 1;
    localparam int ATK_HEAVY   = 2;

    // Result classification returned on res_state
    typedef enum logic [1:0] {
        RES_NO_HIT   = 2'b00,
        RES_CRITICAL = 2'b01,
        RES_NORMAL   = 2'b10,
        RES_MISS     = 2'b11
    } res_state_e;

    // Roll sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MIX  = 2'b01,
        ST_DONE = 2'b10
    } fsm_state_e;

    // Index width that stays at least one bit wide for single-entry ranges
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/attack_roll_engine_if.sv
// Bus bundle between the battle FSM (master) and the roll engine (slave).
// Carries the request handshake, seed reload, threshold table writes and the
// held result handshake. Clock and reset are kept outside as plain ports.
interface attack_roll_engine_if #(
    parameter int WIDTH  = 8,
    parameter int TYPE_W = 4,
    parameter int SEL_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [TYPE_W-1:0] req_type;
    logic              req_is_player;
    logic              seed_load;
    logic [WIDTH-1:0]  seed_val;
    logic              cfg_we;
    logic [SEL_W-1:0]  cfg_sel;
    logic [WIDTH-1:0]  cfg_crit;
    logic [WIDTH-1:0]  cfg_norm;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_state;
    logic [WIDTH-1:0]  res_roll;

    modport master (
        output req_valid, req_type, req_is_player,
        output seed_load, seed_val,
        output cfg_we, cfg_sel, cfg_crit, cfg_norm,
        output res_ready,
        input  req_ready, res_valid, res_state, res_roll
    );

    modport slave (
        input  req_valid, req_type, req_is_player,
        input  seed_load, seed_val,
        input  cfg_we, cfg_sel, cfg_crit, cfg_norm,
        input  res_ready,
        output req_ready, res_valid, res_state, res_roll
    );

endinterface

// File: rtl/attack_roll_engine_lfsr_core.sv
// Free-running XNOR LFSR with synchronous seed load and all-ones lockup recovery.
// Ports: clk, reset (async active-low), load/load_val (seed reload), q (current state).
// Steps every clock; a load takes priority; an all-ones value is never kept.
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hC0,
    parameter logic [WIDTH-1:0] SEED  = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = {q_q[WIDTH-2:0], ~^(q_q & TAPS)};
        if (load) begin
            // All-ones is the XNOR lockup state; substitute the reset seed
            q_d = (load_val == ONES) ? SEED : load_val;
        end else if (q_q == ONES) begin
            q_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/attack_roll_engine.sv
// Attack roll engine: accepts a roll request, mixes the LFSR for STEPS cycles,
// classifies the roll against a programmable per-slot threshold table and holds
// the result until accepted. Ports: clk, reset (async active-low), bus (slave side).
module attack_roll_engine
    import attack_roll_engine_pkg::*;
#(
    parameter int                         WIDTH     = 8,
    parameter int                         NUM_TYPES = 3,
    parameter int                         TYPE_W    = 4,
    parameter logic [WIDTH-1:0]           TAPS      = 8'hC0,
    parameter logic [WIDTH-1:0]           SEED      = 8'h00,
    parameter int                         STEPS     = 4,
    parameter logic [NUM_TYPES*WIDTH-1:0] DEF_CRIT  = {8'd77, 8'd26, 8'd69},
    parameter logic [NUM_TYPES*WIDTH-1:0] DEF_NORM  = {8'd154, 8'd243, 8'd169}
) (
    input  logic                  clk,
    input  logic                  reset,
    attack_roll_engine_if.slave   bus
);

    localparam int SEL_W = clog2_min1(NUM_TYPES);
    localparam int CNT_W = clog2_min1(STEPS);

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lfsr;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_load),
        .load_val (bus.seed_val),
        .q        (lfsr)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [TYPE_W-1:0] type_q,      type_d;
    logic              player_q,    player_d;
    logic              res_valid_q, res_valid_d;
    res_state_e        res_state_q, res_state_d;
    logic [WIDTH-1:0]  res_roll_q,  res_roll_d;
    logic [WIDTH-1:0]  crit_q [NUM_TYPES];
    logic [WIDTH-1:0]  crit_d [NUM_TYPES];
    logic [WIDTH-1:0]  norm_q [NUM_TYPES];
    logic [WIDTH-1:0]  norm_d [NUM_TYPES];

    // ------------------------------------------------------------------
    // Classifier: works on the live LFSR and the registered table, so a
    // table write landing on the completing edge is not seen by that roll.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] slot;
    logic             no_hit;
    res_state_e       cls;

    always_comb begin
        slot   = '0;
        no_hit = 1'b0;
        // CPU attacks always use slot 0 whatever type they carry
        if (player_q) begin
            if (type_q == TYPE_W'(ATK_STANDBY) || int'(type_q) >= NUM_TYPES) begin
                no_hit = 1'b1;
            end else begin
                slot = SEL_W'(type_q);
            end
        end

        if (no_hit) begin
            cls = RES_NO_HIT;
        end else if (lfsr <= crit_q[slot]) begin
            cls = RES_CRITICAL;
        end else if (lfsr <= norm_q[slot]) begin
            cls = RES_NORMAL;
        end else begin
            cls = RES_MISS;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        player_d    = player_q;
        res_valid_d = res_valid_q;
        res_state_d = res_state_q;
        res_roll_d  = res_roll_q;
        crit_d      = crit_q;
        norm_d      = norm_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d  = ST_MIX;
                    cnt_d    = CNT_W'(STEPS - 1);
                    type_d   = bus.req_type;
                    player_d = bus.req_is_player;
                end
            end
            ST_MIX: begin
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_roll_d  = lfsr;
                    res_state_d = cls;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Returning to IDLE here means a new request can only be
                // taken on the following edge.
                if (bus.res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Out-of-range slots are dropped silently
        if (bus.cfg_we && int'(bus.cfg_sel) < NUM_TYPES) begin
            crit_d[bus.cfg_sel] = bus.cfg_crit;
            norm_d[bus.cfg_sel] = bus.cfg_norm;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            type_q      <= '0;
            player_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_state_q <= RES_NO_HIT;
            res_roll_q  <= '0;
            for (int i = 0; i < NUM_TYPES; i++) begin
                crit_q[i] <= DEF_CRIT[i*WIDTH +: WIDTH];
                norm_q[i] <= DEF_NORM[i*WIDTH +: WIDTH];
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            player_q    <= player_d;
            res_valid_q <= res_valid_d;
            res_state_q <= res_state_d;
            res_roll_q  <= res_roll_d;
            for (int i = 0; i < NUM_TYPES; i++) begin
                crit_q[i] <= crit_d[i];
                norm_q[i] <= norm_d[i];
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_state = res_state_q;
    assign bus.res_roll  = res_roll_q;

endmodule

// File: tb/tb_attack_roll_engine.sv
// Directed bench for attack_roll_engine: one instance with STEPS=4, one with STEPS=8.
// Expected rolls, classes and latencies are hand-computed from the LFSR recurrence.
module tb_attack_roll_engine;
    import attack_roll_engine_pkg::*;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    attack_roll_engine_if #(.WIDTH(8), .TYPE_W(4), .SEL_W(2)) ifa ();
    attack_roll_engine_if #(.WIDTH(8), .TYPE_W(4), .SEL_W(2)) ifb ();

    attack_roll_engine #(.STEPS(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    attack_roll_engine #(.STEPS(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Seed load on e0, request accepted on e1, wait for res_valid (left unacknowledged).
    task automatic roll_a(input logic pl, input logic [3:0] ty, input logic [7:0] sd,
                          output logic [7:0] roll, output logic [1:0] st, output int lat);
        ifa.seed_load = 1'b1;
        ifa.seed_val  = sd;
        tick();
        ifa.seed_load     = 1'b0;
        ifa.req_valid     = 1'b1;
        ifa.req_is_player = pl;
        ifa.req_type      = ty;
        tick();
        ifa.req_valid = 1'b0;
        lat = 0;
        while (!ifa.res_valid && lat < 50) begin
            tick();
            lat++;
        end
        roll = ifa.res_roll;
        st   = ifa.res_state;
    endtask

    task automatic ack_a();
        ifa.res_ready = 1'b1;
        tick();
        ifa.res_ready = 1'b0;
    endtask

    task automatic cfg_a(input logic [1:0] sel, input logic [7:0] c, input logic [7:0] n);
        ifa.cfg_we   = 1'b1;
        ifa.cfg_sel  = sel;
        ifa.cfg_crit = c;
        ifa.cfg_norm = n;
        tick();
        ifa.cfg_we = 1'b0;
    endtask

    logic [7:0] roll;
    logic [1:0] st;
    logic [7:0] model;
    int         lat;
    int         bad;
    int         ones;

    initial begin
        reset = 1'b1;
        ifa.req_valid = 0; ifa.req_type = 0; ifa.req_is_player = 0;
        ifa.seed_load = 0; ifa.seed_val = 0; ifa.cfg_we = 0; ifa.cfg_sel = 0;
        ifa.cfg_crit = 0; ifa.cfg_norm = 0; ifa.res_ready = 0;
        ifb.req_valid = 0; ifb.req_type = 0; ifb.req_is_player = 0;
        ifb.seed_load = 0; ifb.seed_val = 0; ifb.cfg_we = 0; ifb.cfg_sel = 0;
        ifb.cfg_crit = 0; ifb.cfg_norm = 0; ifb.res_ready = 0;
        #2 reset = 1'b0;
        #20;
        chk("reset_res_valid", 32'(ifa.res_valid), 32'd0);
        chk("reset_res_state", 32'(ifa.res_state), 32'(RES_NO_HIT));
        chk("reset_res_roll",  32'(ifa.res_roll),  32'd0);
        chk("reset_req_ready", 32'(ifa.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: player LIGHT, LFSR 01,03,07,0F -> 15 <= 26 -> CRITICAL after 4 edges
        roll_a(1'b1, 4'(ATK_LIGHT), 8'h00, roll, st, lat);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_roll", 32'(roll), 32'd15);
        chk("t1_state", 32'(st), 32'(RES_CRITICAL));
        ack_a();
        chk("t1_idle_after_ack", 32'(ifa.req_ready), 32'd1);

        // 2: STEPS=8 CPU request, roll 0xFE > 169 -> MISS, busy throughout
        ifb.seed_load = 1'b1;
        ifb.seed_val  = 8'h00;
        tick();
        ifb.seed_load     = 1'b0;
        ifb.req_valid     = 1'b1;
        ifb.req_is_player = 1'b0;
        ifb.req_type      = 4'(ATK_LIGHT);
        tick();
        ifb.req_valid = 1'b0;
        lat = 0;
        bad = 0;
        while (!ifb.res_valid && lat < 50) begin
            if (ifb.req_ready) bad++;
            tick();
            lat++;
        end
        chk("t2_latency", 32'(lat), 32'd8);
        chk("t2_roll", 32'(ifb.res_roll), 32'hFE);
        chk("t2_state", 32'(ifb.res_state), 32'(RES_MISS));
        chk("t2_ready_low_in_mix", 32'(bad), 32'd0);
        chk("t2_ready_low_in_done", 32'(ifb.req_ready), 32'd0);
        ifb.res_ready = 1'b1;
        tick();
        ifb.res_ready = 1'b0;

        // 3: seeding 0xFF behaves like seeding 0x00
        roll_a(1'b1, 4'(ATK_LIGHT), 8'hFF, roll, st, lat);
        chk("t3_ff_seed_roll", 32'(roll), 32'd15);
        chk("t3_ff_seed_state", 32'(st), 32'(RES_CRITICAL));
        ack_a();
        ifa.seed_load = 1'b1;
        ifa.seed_val  = 8'hFF;
        tick();
        ifa.seed_load = 1'b0;
        chk("t3_ff_load_gives_seed", 32'(dut_a.u_lfsr.q), 32'h00);
        model = 8'h00;
        bad = 0;
        ones = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            model = {model[6:0], ~^(model & 8'hC0)};
            if (dut_a.u_lfsr.q !== model) bad++;
            if (dut_a.u_lfsr.q === 8'hFF) ones++;
        end
        chk("t3_freerun_track", 32'(bad), 32'd0);
        chk("t3_freerun_no_lockup", 32'(ones), 32'd0);

        // 4: slot 1 crit=0 norm=10 -> roll 15 MISS
        cfg_a(2'd1, 8'd0, 8'd10);
        roll_a(1'b1, 4'(ATK_LIGHT), 8'h00, roll, st, lat);
        chk("t4_reprog_state", 32'(st), 32'(RES_MISS));
        ack_a();
        // write on the completing edge: old table (MISS) still applies
        ifa.seed_load = 1'b1;
        ifa.seed_val  = 8'h00;
        tick();
        ifa.seed_load     = 1'b0;
        ifa.req_valid     = 1'b1;
        ifa.req_is_player = 1'b1;
        ifa.req_type      = 4'(ATK_LIGHT);
        tick();
        ifa.req_valid = 1'b0;
        tick();
        tick();
        tick();
        ifa.cfg_we   = 1'b1;
        ifa.cfg_sel  = 2'd1;
        ifa.cfg_crit = 8'd20;
        ifa.cfg_norm = 8'd200;
        tick();
        ifa.cfg_we = 1'b0;
        chk("t4_same_edge_valid", 32'(ifa.res_valid), 32'd1);
        chk("t4_same_edge_old_table", 32'(ifa.res_state), 32'(RES_MISS));
        ack_a();
        roll_a(1'b1, 4'(ATK_LIGHT), 8'h00, roll, st, lat);
        chk("t4_new_table_state", 32'(st), 32'(RES_CRITICAL));
        ack_a();

        // 5: stall in DONE with a pending request
        roll_a(1'b1, 4'(ATK_HEAVY), 8'h00, roll, st, lat);
        chk("t5_heavy_state", 32'(st), 32'(RES_CRITICAL));
        ifa.req_valid     = 1'b1;
        ifa.req_is_player = 1'b1;
        ifa.req_type      = 4'(ATK_LIGHT);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifa.res_valid !== 1'b1 || ifa.res_roll !== 8'd15 ||
                ifa.res_state !== 2'(RES_CRITICAL) || ifa.req_ready !== 1'b0) bad++;
        end
        chk("t5_stall_stable", 32'(bad), 32'd0);
        ifa.res_ready = 1'b1;
        tick();
        ifa.res_ready = 1'b0;
        chk("t5_ack_valid_drop", 32'(ifa.res_valid), 32'd0);
        chk("t5_ack_idle", 32'(ifa.req_ready), 32'd1);
        tick();
        chk("t5_next_accept", 32'(ifa.req_ready), 32'd0);
        ifa.req_valid = 1'b0;
        lat = 0;
        while (!ifa.res_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("t5_next_latency", 32'(lat), 32'd4);
        ack_a();

        // 6: NO_HIT cases and CPU ignoring type
        roll_a(1'b1, 4'(ATK_STANDBY), 8'h00, roll, st, lat);
        chk("t6_type0_latency", 32'(lat), 32'd4);
        chk("t6_type0_state", 32'(st), 32'(RES_NO_HIT));
        ack_a();
        roll_a(1'b1, 4'd5, 8'h00, roll, st, lat);
        chk("t6_type5_state", 32'(st), 32'(RES_NO_HIT));
        ack_a();
        cfg_a(2'd3, 8'd0, 8'd0);
        roll_a(1'b0, 4'd5, 8'h00, roll, st, lat);
        chk("t6_cpu_type5_slot0", 32'(st), 32'(RES_CRITICAL));
        ack_a();

        // HEAVY with seed 0x08: 11,23,47,8E -> 142, between 77 and 154 -> NORMAL
        roll_a(1'b1, 4'(ATK_HEAVY), 8'h08, roll, st, lat);
        chk("t7_heavy_roll", 32'(roll), 32'd142);
        chk("t7_heavy_normal", 32'(st), 32'(RES_NORMAL));
        ack_a();
        cfg_a(2'd2, 8'd142, 8'd200);
        roll_a(1'b1, 4'(ATK_HEAVY), 8'h08, roll, st, lat);
        chk("t7_eq_crit", 32'(st), 32'(RES_CRITICAL));
        ack_a();
        cfg_a(2'd2, 8'd141, 8'd142);
        roll_a(1'b1, 4'(ATK_HEAVY), 8'h08, roll, st, lat);
        chk("t7_eq_norm", 32'(st), 32'(RES_NORMAL));
        ack_a();
        cfg_a(2'd2, 8'd141, 8'd141);
        roll_a(1'b1, 4'(ATK_HEAVY), 8'h08, roll, st, lat);
        chk("t7_above_norm", 32'(st), 32'(RES_MISS));
        ack_a();

        // 8: reset pulse in the middle of a roll
        ifa.seed_load = 1'b1;
        ifa.seed_val  = 8'h00;
        tick();
        ifa.seed_load     = 1'b0;
        ifa.req_valid     = 1'b1;
        ifa.req_is_player = 1'b1;
        ifa.req_type      = 4'(ATK_LIGHT);
        tick();
        ifa.req_valid = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("t8_in_reset_ready", 32'(ifa.req_ready), 32'd1);
        #1 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifa.res_valid !== 1'b0) bad++;
        end
        chk("t8_no_result", 32'(bad), 32'd0);
        chk("t8_res_state", 32'(ifa.res_state), 32'(RES_NO_HIT));
        chk("t8_res_roll", 32'(ifa.res_roll), 32'd0);
        chk("t8_idle", 32'(ifa.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
